// File: rtl/bht_update_sched.sv
// bht_update_sched
//   Owns the single write port of the branch history table (BHT).
//   - INIT: after reset or a clear request, writes every BHT entry once so
//     that the entry ends up weakly-not-taken. This is needed because the
//     BHT RAMs are not reset.
//   - RUN: merges two branch-resolution update slots into a small in-order
//     queue and drains one write per cycle. Updates that do not fit are
//     dropped and counted; the pipeline is never stalled.
//
// Update record layout (36 bits, MSB first):
//   [35] valid, [34:3] pc, [2:1] counter, [0] taken
//
// Ports
//   clk           clock, rising edge
//   rst           asynchronous, active-low reset
//   upd_i         two update records: slot 0 = [35:0] (older),
//                 slot 1 = [71:36] (younger)
//   clear_i       one-cycle request to re-initialise the table
//   bht_update_o  registered write command to the BHT
//   init_busy_o   high while the table contents are not yet valid
//   drop_cnt_o    saturating count of discarded updates
module bht_update_sched #(
    parameter int SIZE  = 4096,
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [71:0] upd_i,
    input  logic        clear_i,
    output logic [35:0] bht_update_o,
    output logic        init_busy_o,
    output logic [15:0] drop_cnt_o
);

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [1:0]  counter;
        logic        taken;
    } bht_update_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int IW = $clog2(SIZE);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    state_t         state, state_next;
    logic [IW-1:0]  idx, idx_next;
    logic [PW-1:0]  wr_ptr, wr_ptr_next, wr_ptr_inc;
    logic [PW-1:0]  rd_ptr, rd_ptr_next;
    logic [CW-1:0]  count, count_next, free;
    bht_update_t    mem [DEPTH];
    bht_update_t    slot0, slot1, first, out_q, out_next;
    logic [1:0]     n_cand, n_push, n_drop;
    logic           pop;
    logic [15:0]    drop_next;

    // Adds 0..2 drops to the counter, sticking at all-ones.
    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {15'd0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    // Sweep write for entry i: counter 00 with taken=1 makes the BHT's
    // next-counter logic store 01 (weakly-not-taken).
    function automatic bht_update_t sweep_write(input logic [IW-1:0] i);
        bht_update_t w;
        w.valid   = 1'b1;
        w.pc      = 32'(i) << 2;
        w.counter = 2'b00;
        w.taken   = 1'b1;
        return w;
    endfunction

    assign slot0        = upd_i[35:0];
    assign slot1        = upd_i[71:36];
    assign bht_update_o = out_q;
    assign init_busy_o  = (state == INIT);
    assign free         = CW'(DEPTH) - count;
    assign wr_ptr_inc   = wr_ptr + PW'(1);

    always_comb begin
        state_next  = state;
        idx_next    = idx;
        wr_ptr_next = wr_ptr;
        rd_ptr_next = rd_ptr;
        count_next  = count;
        out_next    = '0;
        n_cand      = 2'd0;
        n_push      = 2'd0;
        n_drop      = 2'd0;
        pop         = 1'b0;
        first       = slot0;
        drop_next   = drop_cnt_o;

        if (clear_i) begin
            // Restart the sweep and throw away anything queued; this
            // cycle's updates are discarded without being counted.
            state_next  = INIT;
            idx_next    = '0;
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
            out_next    = sweep_write('0);
        end else begin
            case (state)
                INIT: begin
                    out_next = sweep_write(idx);
                    idx_next = idx + IW'(1);
                    if (idx == IW'(SIZE - 1)) begin
                        state_next = RUN;
                    end
                end
                RUN: begin
                    // A lone slot-1 update is treated like a slot-0 one.
                    n_cand = {1'b0, slot0.valid} + {1'b0, slot1.valid};
                    first  = slot0.valid ? slot0 : slot1;
                    // Free space is judged before this cycle's pop.
                    if (free >= CW'(n_cand)) begin
                        n_push = n_cand;
                    end else begin
                        n_push = free[1:0];
                    end
                    n_drop = n_cand - n_push;

                    pop = (count != '0);
                    if (pop) begin
                        out_next       = mem[rd_ptr];
                        out_next.valid = 1'b1;
                        rd_ptr_next    = rd_ptr + PW'(1);
                    end

                    wr_ptr_next = wr_ptr + PW'(n_push);
                    count_next  = count + CW'(n_push) - CW'(pop);
                    drop_next   = sat_add(drop_cnt_o, n_drop);
                end
                default: begin
                    state_next = INIT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= INIT;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            out_q      <= '0;
            drop_cnt_o <= '0;
        end else begin
            idx        <= idx_next;
            wr_ptr     <= wr_ptr_next;
            rd_ptr     <= rd_ptr_next;
            count      <= count_next;
            out_q      <= out_next;
            drop_cnt_o <= drop_next;
        end
    end

    // Queue storage holds data only; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (n_push != 2'd0) begin
            mem[wr_ptr] <= first;
        end
        if (n_push == 2'd2) begin
            mem[wr_ptr_inc] <= slot1;
        end
    end

endmodule

// File: tb/tb_bht_update_sched.sv
// Directed bench for bht_update_sched with SIZE=16, DEPTH=4.
// Inputs change and outputs are checked on the falling clock edge.
module tb_bht_update_sched;

    logic        clk;
    logic        rst;
    logic [71:0] upd_i;
    logic        clear_i;
    logic [35:0] bht_update_o;
    logic        init_busy_o;
    logic [15:0] drop_cnt_o;

    int vectors    = 0;
    int miscompares = 0;
    int n;

    bht_update_sched #(.SIZE(16), .DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .upd_i       (upd_i),
        .clear_i     (clear_i),
        .bht_update_o(bht_update_o),
        .init_busy_o (init_busy_o),
        .drop_cnt_o  (drop_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [35:0] mk(input logic v, input logic [31:0] pc,
                                       input logic [1:0] c, input logic t);
        return {v, pc, c, t};
    endfunction

    function automatic logic [35:0] sw(input int i);
        return mk(1'b1, 32'(i * 4), 2'b00, 1'b1);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [35:0] a0, a1, b0, b1, c0, c1, d0, d1, e0, e1, f0, f1, g0, g1;

    initial begin
        a0 = mk(1'b1, 32'h2000, 2'b00, 1'b0);
        a1 = mk(1'b1, 32'h2004, 2'b01, 1'b1);
        b0 = mk(1'b1, 32'h2008, 2'b11, 1'b0);
        b1 = mk(1'b1, 32'h200C, 2'b10, 1'b1);
        c0 = mk(1'b1, 32'h2010, 2'b01, 1'b0);
        c1 = mk(1'b1, 32'h2014, 2'b11, 1'b1);
        d0 = mk(1'b1, 32'h3000, 2'b10, 1'b0);
        d1 = mk(1'b1, 32'h3004, 2'b01, 1'b1);
        e0 = mk(1'b1, 32'h4000, 2'b11, 1'b1);
        e1 = mk(1'b1, 32'h4004, 2'b00, 1'b0);
        f0 = mk(1'b1, 32'h4008, 2'b01, 1'b1);
        f1 = mk(1'b1, 32'h400C, 2'b10, 1'b0);
        g0 = mk(1'b1, 32'h5000, 2'b11, 1'b1);
        g1 = mk(1'b1, 32'h5004, 2'b11, 1'b0);

        rst     = 1'b0;
        clear_i = 1'b0;
        upd_i   = '0;
        repeat (2) @(negedge clk);
        chk("rst_out", bht_update_o, 0);
        chk("rst_busy", init_busy_o, 1);
        chk("rst_drop", drop_cnt_o, 0);

        // Initial sweep, with updates offered that must be ignored
        rst   = 1'b1;
        upd_i = {a1, a0};
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk("sweep_wr", bht_update_o, sw(k));
            chk("sweep_busy", init_busy_o, (k != 15) ? 1 : 0);
        end
        chk("sweep_drop", drop_cnt_o, 0);
        upd_i = '0;
        @(negedge clk);
        chk("idle_out", bht_update_o, 0);

        // Single update, two-cycle latency
        upd_i[35:0] = mk(1'b1, 32'h1000, 2'b10, 1'b1);
        @(negedge clk);
        upd_i = '0;
        chk("lat_early", bht_update_o, 0);
        @(negedge clk);
        chk("lat_out", bht_update_o, mk(1'b1, 32'h1000, 2'b10, 1'b1));
        @(negedge clk);
        chk("lat_after", bht_update_o, 0);

        // Three dual-slot cycles: C1 is dropped
        upd_i = {a1, a0};
        @(negedge clk);
        chk("burst_e1", bht_update_o, 0);
        upd_i = {b1, b0};
        @(negedge clk);
        chk("burst_a0", bht_update_o, a0);
        upd_i = {c1, c0};
        @(negedge clk);
        chk("burst_a1", bht_update_o, a1);
        chk("burst_drop", drop_cnt_o, 1);
        upd_i = '0;
        @(negedge clk);
        chk("burst_b0", bht_update_o, b0);
        @(negedge clk);
        chk("burst_b1", bht_update_o, b1);
        @(negedge clk);
        chk("burst_c0", bht_update_o, c0);
        @(negedge clk);
        chk("burst_end", bht_update_o, 0);
        chk("burst_drop_end", drop_cnt_o, 1);

        // Slot 1 alone is accepted
        upd_i[71:36] = b1;
        @(negedge clk);
        upd_i = '0;
        @(negedge clk);
        chk("slot1_only", bht_update_o, b1);
        chk("slot1_drop", drop_cnt_o, 1);
        @(negedge clk);

        // Clear with three entries queued (E1, F0, F1)
        upd_i = {e1, e0};
        @(negedge clk);
        upd_i = {f1, f0};
        @(negedge clk);
        chk("preclr_e0", bht_update_o, e0);
        chk("preclr_drop", drop_cnt_o, 1);
        clear_i = 1'b1;
        upd_i   = {g1, g0};
        @(negedge clk);
        clear_i = 1'b0;
        upd_i   = '0;
        chk("clr_out", bht_update_o, sw(0));
        chk("clr_busy", init_busy_o, 1);
        chk("clr_drop", drop_cnt_o, 1);

        // Clear during the sweep restarts it
        repeat (3) @(negedge clk);
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        chk("clr_init_out", bht_update_o, sw(0));
        chk("clr_init_busy", init_busy_o, 1);

        n = 0;
        while (init_busy_o !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("clr_run", init_busy_o, 0);
        chk("clr_last", bht_update_o, sw(15));
        @(negedge clk);
        chk("flush_out1", bht_update_o, 0);
        @(negedge clk);
        chk("flush_out2", bht_update_o, 0);
        chk("flush_drop", drop_cnt_o, 1);

        // Continuous dual-slot traffic: saturation of the drop counter
        upd_i = {d1, d0};
        @(negedge clk);
        chk("sat_e1_drop", drop_cnt_o, 1);
        @(negedge clk);
        chk("sat_e2_out", bht_update_o, d0);
        chk("sat_e2_drop", drop_cnt_o, 1);
        @(negedge clk);
        chk("sat_e3_out", bht_update_o, d1);
        chk("sat_e3_drop", drop_cnt_o, 2);
        n = 0;
        while (drop_cnt_o !== 16'hFFFE && n < 70000) begin
            @(negedge clk);
            n++;
        end
        chk("sat_fffe", drop_cnt_o, 16'hFFFE);
        @(negedge clk);
        chk("sat_ffff", drop_cnt_o, 16'hFFFF);
        @(negedge clk);
        chk("sat_hold", drop_cnt_o, 16'hFFFF);
        chk("sat_out_vld", bht_update_o[35], 1);
        upd_i = '0;

        // Reset clears the counter immediately
        rst = 1'b0;
        #1;
        chk("rst2_drop", drop_cnt_o, 0);
        chk("rst2_out", bht_update_o, 0);
        @(negedge clk);
        rst = 1'b1;

        // Reset mid-sweep at idx=7
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            chk("sweep2_wr", bht_update_o, sw(k));
        end
        rst = 1'b0;
        #1;
        chk("midrst_out", bht_update_o, 0);
        chk("midrst_busy", init_busy_o, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("restart_pc0", bht_update_o, sw(0));
        @(negedge clk);
        chk("restart_pc4", bht_update_o, sw(1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
